// File: rtl/bridge_scheduler.sv
`default_nettype none
//==============================================================================
// Module   : bridge_scheduler
// Purpose  : Round-robin two-port scheduler for the SD/DRAM bridge; reassembles
//            the 8-byte output burst into a 64-bit result with watchdog abort.
// Revision : 1.0
//==============================================================================
module bridge_scheduler #(
  parameter logic [19:0] TIMEOUT = 20'd200000,
  parameter int          CNT_W   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        req0_direction,
  input  logic        req1_direction,
  input  logic [12:0] req0_addr_dram,
  input  logic [12:0] req1_addr_dram,
  input  logic [15:0] req0_addr_sd,
  input  logic [15:0] req1_addr_sd,
  output logic        bridge_in_valid,
  output logic        bridge_direction,
  output logic [12:0] bridge_addr_dram,
  output logic [15:0] bridge_addr_sd,
  input  logic        bridge_out_valid,
  input  logic [7:0]  bridge_out_data,
  output logic        done,
  output logic        done_id,
  output logic [63:0] done_data,
  output logic        done_err,
  output logic        busy
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_ISSUE   = 3'd1;
  localparam logic [2:0] c_WAIT    = 3'd2;
  localparam logic [2:0] c_COLLECT = 3'd3;
  localparam logic [2:0] c_DONE    = 3'd4;

  localparam logic [CNT_W-1:0] c_WD_LAST = CNT_W'(TIMEOUT - 20'd1);

  logic [2:0]       r_state;
  logic             r_last_id;
  logic             r_id;
  logic [CNT_W-1:0] r_wd;
  logic [3:0]       r_cnt;
  logic [55:0]      r_shreg;
  logic             r_in_valid;
  logic             r_dir;
  logic [12:0]      r_addr_dram;
  logic [15:0]      r_addr_sd;
  logic             r_done;
  logic             r_done_id;
  logic [63:0]      r_done_data;
  logic             r_done_err;
  logic             r_busy;

  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;
  logic [63:0]      w_shreg_next;

  // On a tie the requester that was not served last wins.
  assign w_idle       = (r_state == c_IDLE);
  assign w_grant0     = w_idle & req0_valid & (~req1_valid | r_last_id);
  assign w_grant1     = w_idle & req1_valid & (~req0_valid | ~r_last_id);
  assign w_shreg_next = {r_shreg, bridge_out_data};

  assign req0_ready       = w_grant0;
  assign req1_ready       = w_grant1;
  assign bridge_in_valid  = r_in_valid;
  assign bridge_direction = r_dir;
  assign bridge_addr_dram = r_addr_dram;
  assign bridge_addr_sd   = r_addr_sd;
  assign done             = r_done;
  assign done_id          = r_done_id;
  assign done_data        = r_done_data;
  assign done_err         = r_done_err;
  assign busy             = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_last_id   <= 1'b1;
      r_id        <= 1'b0;
      r_wd        <= '0;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_in_valid  <= 1'b0;
      r_dir       <= 1'b0;
      r_addr_dram <= '0;
      r_addr_sd   <= '0;
      r_done      <= 1'b0;
      r_done_id   <= 1'b0;
      r_done_data <= '0;
      r_done_err  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= 1'b0;
      r_done_data <= '0;
      r_done_err  <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_grant0 | w_grant1) begin
            r_id        <= w_grant1;
            r_dir       <= w_grant1 ? req1_direction : req0_direction;
            r_addr_dram <= w_grant1 ? req1_addr_dram : req0_addr_dram;
            r_addr_sd   <= w_grant1 ? req1_addr_sd : req0_addr_sd;
            r_in_valid  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          r_wd    <= '0;
          r_state <= c_WAIT;
        end
        c_WAIT: begin
          if (bridge_out_valid) begin
            r_shreg <= w_shreg_next[55:0];
            r_cnt   <= 4'd1;
            r_state <= c_COLLECT;
          end else if (r_wd == c_WD_LAST) begin
            r_done     <= 1'b1;
            r_done_id  <= r_id;
            r_done_err <= 1'b1;
            r_state    <= c_DONE;
          end else begin
            r_wd <= r_wd + CNT_W'(1);
          end
        end
        c_COLLECT: begin
          if (bridge_out_valid) begin
            r_shreg <= w_shreg_next[55:0];
            r_cnt   <= r_cnt + 4'd1;
            // The eighth byte completes the word straight from the shift path.
            if (r_cnt == 4'd7) begin
              r_done      <= 1'b1;
              r_done_id   <= r_id;
              r_done_data <= w_shreg_next;
              r_state     <= c_DONE;
            end
          end else begin
            r_done     <= 1'b1;
            r_done_id  <= r_id;
            r_done_err <= 1'b1;
            r_state    <= c_DONE;
          end
        end
        c_DONE: begin
          r_last_id   <= r_id;
          r_cnt       <= '0;
          r_dir       <= 1'b0;
          r_addr_dram <= '0;
          r_addr_sd   <= '0;
          r_busy      <= 1'b0;
          r_state     <= c_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bridge_scheduler.sv
`default_nettype none
//==============================================================================
// Module   : tb_bridge_scheduler
// Purpose  : Self-checking bench for bridge_scheduler against a transfer-level
//            timeline model.
// Revision : 1.0
//==============================================================================
module tb_bridge_scheduler;

  localparam logic [19:0] c_TO   = 20'd16;
  localparam int          c_TOI  = 16;
  localparam int          c_PATN = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic        req0_direction = 1'b0, req1_direction = 1'b0;
  logic [12:0] req0_addr_dram = '0, req1_addr_dram = '0;
  logic [15:0] req0_addr_sd = '0, req1_addr_sd = '0;
  logic        bridge_in_valid, bridge_direction;
  logic [12:0] bridge_addr_dram;
  logic [15:0] bridge_addr_sd;
  logic        bridge_out_valid = 1'b0;
  logic [7:0]  bridge_out_data = '0;
  logic        done, done_id, done_err, busy;
  logic [63:0] done_data;

  always #5 clk = ~clk;

  bridge_scheduler #(.TIMEOUT(c_TO), .CNT_W(20)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_direction(req0_direction), .req1_direction(req1_direction),
    .req0_addr_dram(req0_addr_dram), .req1_addr_dram(req1_addr_dram),
    .req0_addr_sd(req0_addr_sd), .req1_addr_sd(req1_addr_sd),
    .bridge_in_valid(bridge_in_valid), .bridge_direction(bridge_direction),
    .bridge_addr_dram(bridge_addr_dram), .bridge_addr_sd(bridge_addr_sd),
    .bridge_out_valid(bridge_out_valid), .bridge_out_data(bridge_out_data),
    .done(done), .done_id(done_id), .done_data(done_data),
    .done_err(done_err), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Stimulus knobs
  bit          k_rst = 1'b1, k_v0 = 1'b0, k_v1 = 1'b0, k_d0 = 1'b0, k_d1 = 1'b0;
  logic [12:0] k_ad0 = '0, k_ad1 = '0;
  logic [15:0] k_as0 = '0, k_as1 = '0;
  bit          k_drop = 1'b0, k_seq = 1'b0, k_spur_all = 1'b0;
  int          k_mode = 0, k_delay = 1, k_len = 1;
  logic [7:0]  k_base = '0;

  // Transfer timeline model
  bit          m_active = 1'b0, m_last = 1'b1, m_id = 1'b0, m_dir = 1'b0, m_err = 1'b0;
  int          m_in = 0, m_done = 0;
  logic [12:0] m_ad = '0;
  logic [15:0] m_as = '0;
  logic [63:0] m_data = '0;
  bit          pat_v [c_PATN];
  logic [7:0]  pat_d [c_PATN];

  // Observations of DUT events for the directed literal checks
  int          n_done = 0, n_iv = 0, o_in_cyc = 0, o_done_cyc = 0;
  logic [12:0] o_ad = '0;
  logic [15:0] o_as = '0;
  bit          o_dir = 1'b0, o_id = 1'b0, o_err = 1'b0;
  logic [63:0] o_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Bridge response for one transfer, indexed by cycles after the in_valid pulse.
  task automatic build_pattern();
    int b;
    for (int k = 0; k < c_PATN; k++) begin
      pat_v[k] = ($urandom % 2) == 1;
      pat_d[k] = 8'($urandom);
    end
    b = k_delay;
    if (k_mode == 2) begin
      for (int k = 1; k <= c_TOI; k++) pat_v[k] = 1'b0;
    end else begin
      for (int k = 1; k < b; k++) pat_v[k] = 1'b0;
      for (int j = 0; j < 8; j++) begin
        pat_v[b+j] = (k_mode == 0) || (j < k_len);
        if (k_seq) pat_d[b+j] = k_base + 8'(j + 1);
      end
    end
  endtask

  // Derive the expected completion purely from the byte schedule.
  task automatic predict();
    int b;
    int len;
    b = -1;
    for (int k = 1; k <= c_TOI; k++)
      if (b < 0 && pat_v[k]) b = k;
    m_data = '0;
    if (b < 0) begin
      m_done = m_in + c_TOI + 1;
      m_err  = 1'b1;
    end else begin
      len = 0;
      while (len < 8 && pat_v[b+len]) len++;
      if (len == 8) begin
        m_done = m_in + b + 8;
        m_err  = 1'b0;
        for (int j = 0; j < 8; j++) m_data = {m_data[55:0], pat_d[b+j]};
      end else begin
        m_done = m_in + b + len + 1;
        m_err  = 1'b1;
      end
    end
  endtask

  task automatic step();
    bit          e_r0, e_r1, e_iv, e_busy, e_dir, e_done;
    logic [12:0] e_ad;
    logic [15:0] e_as;
    int          k;
    @(posedge clk);
    #1;
    cyc++;
    rst            = k_rst;
    req0_valid     = k_v0;
    req1_valid     = k_v1;
    req0_direction = k_d0;
    req1_direction = k_d1;
    req0_addr_dram = k_ad0;
    req1_addr_dram = k_ad1;
    req0_addr_sd   = k_as0;
    req1_addr_sd   = k_as1;
    k = cyc - m_in;
    if (m_active && k >= 0 && k < c_PATN) begin
      bridge_out_valid = pat_v[k];
      bridge_out_data  = pat_d[k];
    end else if (k_spur_all) begin
      bridge_out_valid = 1'b1;
      bridge_out_data  = 8'hEE;
    end else begin
      bridge_out_valid = ($urandom % 4) == 0;
      bridge_out_data  = 8'($urandom);
    end
    @(negedge clk);

    if (m_active) begin
      e_r0 = 1'b0; e_r1 = 1'b0; e_iv = (cyc == m_in); e_busy = 1'b1;
      e_dir = m_dir; e_ad = m_ad; e_as = m_as; e_done = (cyc == m_done);
    end else begin
      e_r0 = k_v0 && (!k_v1 || m_last);
      e_r1 = k_v1 && (!k_v0 || !m_last);
      e_iv = 1'b0; e_busy = 1'b0; e_dir = 1'b0; e_ad = '0; e_as = '0; e_done = 1'b0;
    end
    chk("req0_ready", 64'(req0_ready), 64'(e_r0));
    chk("req1_ready", 64'(req1_ready), 64'(e_r1));
    chk("in_valid", 64'(bridge_in_valid), 64'(e_iv));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("direction", 64'(bridge_direction), 64'(e_dir));
    chk("addr_dram", 64'(bridge_addr_dram), 64'(e_ad));
    chk("addr_sd", 64'(bridge_addr_sd), 64'(e_as));
    chk("done", 64'(done), 64'(e_done));
    if (e_done) begin
      chk("done_id", 64'(done_id), 64'(m_id));
      chk("done_data", done_data, m_data);
      chk("done_err", 64'(done_err), 64'(m_err));
    end

    if (bridge_in_valid) begin
      n_iv++; o_in_cyc = cyc; o_ad = bridge_addr_dram; o_as = bridge_addr_sd;
      o_dir = bridge_direction;
    end
    if (done) begin
      n_done++; o_done_cyc = cyc; o_id = done_id; o_data = done_data; o_err = done_err;
    end

    if (k_rst) begin
      m_active = 1'b0;
      m_last   = 1'b1;
    end else if (m_active) begin
      if (cyc == m_done) begin
        m_active = 1'b0;
        m_last   = m_id;
      end
    end else if (e_r0 || e_r1) begin
      m_active = 1'b1;
      m_id     = e_r1;
      m_dir    = e_r1 ? k_d1 : k_d0;
      m_ad     = e_r1 ? k_ad1 : k_ad0;
      m_as     = e_r1 ? k_as1 : k_as0;
      m_in     = cyc + 1;
      build_pattern();
      predict();
      if (k_drop) begin
        k_v0 = 1'b0;
        k_v1 = 1'b0;
      end
    end
  endtask

  task automatic run_until_done(input int bound);
    int n0;
    int i;
    n0 = n_done;
    i  = 0;
    while (n_done == n0 && i < bound) begin
      step();
      i++;
    end
    chk("done_within_bound", 64'(n_done - n0), 64'd1);
  endtask

  task automatic do_reset();
    k_rst = 1'b1;
    step();
    step();
    k_rst = 1'b0;
  endtask

  initial begin
    int n0;
    int i;
    do_reset();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_valid", 64'(bridge_in_valid), 64'd0);

    // Single req0 transfer with bytes 01..08 three cycles after in_valid
    k_drop = 1'b1; k_seq = 1'b1; k_base = 8'h00; k_mode = 0; k_delay = 3;
    k_v0 = 1'b1; k_d0 = 1'b1; k_ad0 = 13'h1ABC; k_as0 = 16'hBEEF;
    n0 = n_iv;
    run_until_done(40);
    chk("t1_in_pulses", 64'(n_iv - n0), 64'd1);
    chk("t1_addr_dram", 64'(o_ad), 64'h1ABC);
    chk("t1_addr_sd", 64'(o_as), 64'hBEEF);
    chk("t1_dir", 64'(o_dir), 64'd1);
    chk("t1_id", 64'(o_id), 64'd0);
    chk("t1_data", o_data, 64'h0102030405060708);
    chk("t1_err", 64'(o_err), 64'd0);
    chk("t1_latency", 64'(o_done_cyc - o_in_cyc), 64'd11);

    // Round-robin with both requesters permanently valid
    do_reset();
    k_drop = 1'b0; k_seq = 1'b0; k_v0 = 1'b1; k_v1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      k_delay = 1 + t;
      run_until_done(40);
      chk("rr_grant", 64'(o_id), 64'(t % 2));
    end
    k_v0 = 1'b0; k_v1 = 1'b0;
    step();
    step();

    // Timeout
    k_drop = 1'b1; k_mode = 2; k_v0 = 1'b1;
    run_until_done(60);
    chk("to_err", 64'(o_err), 64'd1);
    chk("to_data", o_data, 64'd0);
    chk("to_latency", 64'(o_done_cyc - o_in_cyc), 64'd17);

    // Short burst of five bytes starting two cycles after in_valid
    k_mode = 1; k_delay = 2; k_len = 5; k_v1 = 1'b1;
    run_until_done(60);
    chk("short_err", 64'(o_err), 64'd1);
    chk("short_latency", 64'(o_done_cyc - o_in_cyc), 64'd8);

    // Reset while collecting, after four bytes
    k_mode = 0; k_delay = 2; k_v0 = 1'b1;
    n0 = n_iv;
    i  = 0;
    while (n_iv == n0 && i < 20) begin
      step();
      i++;
    end
    chk("rc_issue_seen", 64'(n_iv - n0), 64'd1);
    repeat (5) step();
    n0 = n_done;
    k_rst = 1'b1;
    step();
    k_rst = 1'b0;
    step();
    chk("rc_busy", 64'(busy), 64'd0);
    chk("rc_done", 64'(done), 64'd0);
    chk("rc_addr_dram", 64'(bridge_addr_dram), 64'd0);
    chk("rc_addr_sd", 64'(bridge_addr_sd), 64'd0);
    chk("rc_dir", 64'(bridge_direction), 64'd0);
    repeat (20) step();
    chk("rc_no_done", 64'(n_done - n0), 64'd0);
    k_v1 = 1'b1; k_delay = 4;
    run_until_done(40);
    chk("rc_next_id", 64'(o_id), 64'd1);
    chk("rc_next_err", 64'(o_err), 64'd0);

    // Spurious bytes while idle must not leak into the result
    k_spur_all = 1'b1;
    repeat (5) step();
    k_seq = 1'b1; k_base = 8'h10; k_delay = 3; k_v0 = 1'b1;
    run_until_done(40);
    k_spur_all = 1'b0; k_seq = 1'b0;
    chk("spur_data", o_data, 64'h1112131415161718);
    chk("spur_err", 64'(o_err), 64'd0);

    // Randomised traffic
    k_drop = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      k_v0    = ($urandom % 3) != 0;
      k_v1    = ($urandom % 3) != 0;
      k_d0    = ($urandom % 2) == 1;
      k_d1    = ($urandom % 2) == 1;
      k_ad0   = 13'($urandom);
      k_ad1   = 13'($urandom);
      k_as0   = 16'($urandom);
      k_as1   = 16'($urandom);
      k_mode  = ($urandom % 4 == 3) ? 2 : (($urandom % 3 == 0) ? 1 : 0);
      k_delay = 1 + int'($urandom % c_TOI);
      k_len   = 1 + int'($urandom % 7);
      k_rst   = ($urandom % 500) == 0;
      step();
    end
    k_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
